// File: rtl/periph_bus_initiator.sv
// Burst initiator: turns one command into 1..256 single-word beats on a native
// valid/ready memory bus, with a per-beat timeout and read/write data streams.
module periph_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        done,
  output logic        err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  // Every stream transfers on a cycle where valid && ready are both sampled 1;
  // a producer holds valid and its payload stable until that cycle.

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GETW = 3'd1,
    ST_BUS  = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [7:0]  beats_q;
  logic        write_q;
  logic        last_q;
  logic        err_q;
  logic [15:0] tmo_cnt;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        cmd_fire;
  logic        tmo_hit;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_addr[1:0];

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign tmo_hit   = (state == ST_BUS) && !mem_ready && (tmo_cnt == TMO_LIMIT);

  assign wr_ready  = (state == ST_GETW);
  assign mem_valid = (state == ST_BUS);
  assign rsp_valid = (state == ST_RESP);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_DONE) && err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign rsp_data  = rdata_q;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_fire) state_next = cmd_write ? ST_GETW : ST_BUS;
      ST_GETW: if (wr_valid) state_next = ST_BUS;
      ST_BUS: begin
        if (mem_ready) begin
          if (!write_q)           state_next = ST_RESP;
          else if (beats_q == '0) state_next = ST_DONE;
          else                    state_next = ST_GETW;
        end else if (tmo_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_RESP: if (rsp_ready) state_next = last_q ? ST_DONE : ST_BUS;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      write_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (cmd_fire) begin
        addr_q  <= {cmd_addr[31:2], 2'b00};
        beats_q <= cmd_len;
        write_q <= cmd_write;
        last_q  <= 1'b0;
        err_q   <= 1'b0;
        // Reads never carry byte enables onto the bus.
        if (!cmd_write) wstrb_q <= '0;
      end
      if ((state == ST_GETW) && wr_valid) begin
        wdata_q <= wr_data;
        wstrb_q <= wr_strb;
      end
      if (state == ST_BUS) begin
        if (mem_ready) begin
          addr_q <= addr_q + 32'd4;
          last_q <= (beats_q == '0);
          if (beats_q != '0) beats_q <= beats_q - 8'd1;
          if (!write_q) rdata_q <= mem_rdata;
        end else if (tmo_hit) begin
          err_q <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end else begin
        // Cleared outside BUS so every beat starts its wait count at zero.
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Directed bench for periph_bus_initiator (TIMEOUT_CYCLES=4): inputs are driven
// and outputs sampled on the falling edge.
module tb_periph_bus_initiator;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        done;
  logic        err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  periph_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .err(err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge sys_clk);
  endtask

  // Offer one command; returns on the falling edge after acceptance.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = len;
    #1;
    chk("cmd_ready idle", cmd_ready, 1);
    next_cyc();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    chk("cmd_ready busy", cmd_ready, 0);
  endtask

  // Entered with the DUT in BUS for a read beat.
  task automatic read_beat(input logic [31:0] a, input logic [31:0] d,
                           input int wait_cycles, input int hold_cycles);
    chk("rd mem_valid", mem_valid, 1);
    chk("rd mem_addr", mem_addr, a);
    chk("rd mem_wstrb", mem_wstrb, 0);
    for (int i = 0; i < wait_cycles; i++) begin
      next_cyc();
      chk("rd wait mem_valid", mem_valid, 1);
      chk("rd wait mem_addr", mem_addr, a);
    end
    mem_ready = 1'b1;
    mem_rdata = d;
    next_cyc();
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    chk("rd gap mem_valid", mem_valid, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, d);
    for (int i = 0; i < hold_cycles; i++) begin
      next_cyc();
      chk("hold rsp_valid", rsp_valid, 1);
      chk("hold rsp_data", rsp_data, d);
      chk("hold mem_valid", mem_valid, 0);
    end
    rsp_ready = 1'b1;
    next_cyc();
    rsp_ready = 1'b0;
    chk("rsp_valid after hs", rsp_valid, 0);
  endtask

  // Entered with the DUT in GETW for a write beat.
  task automatic write_beat(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wait_cycles);
    chk("wr_ready getw", wr_ready, 1);
    chk("wr mem_valid getw", mem_valid, 0);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_strb  = s;
    next_cyc();
    wr_valid = 1'b0;
    wr_data  = 32'h0BAD_0BAD;
    wr_strb  = 4'h0;
    chk("wr_ready bus", wr_ready, 0);
    chk("wr mem_valid", mem_valid, 1);
    chk("wr mem_addr", mem_addr, a);
    chk("wr mem_wdata", mem_wdata, d);
    chk("wr mem_wstrb", mem_wstrb, s);
    for (int i = 0; i < wait_cycles; i++) begin
      next_cyc();
      chk("wr wait mem_valid", mem_valid, 1);
      chk("wr wait mem_wdata", mem_wdata, d);
    end
    mem_ready = 1'b1;
    next_cyc();
    mem_ready = 1'b0;
    chk("wr gap mem_valid", mem_valid, 0);
    chk("wr rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    // reset
    next_cyc();
    #1;
    chk("reset cmd_ready", cmd_ready, 0);
    next_cyc();
    chk("reset state", state_dbg, 0);
    chk("reset mem_valid", mem_valid, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset wr_ready", wr_ready, 0);
    chk("reset mem_addr", mem_addr, 0);
    rst = 1'b0;
    #1;
    chk("post-reset cmd_ready", cmd_ready, 1);
    next_cyc();

    // read burst of 3 from unaligned 0x1003, one wait per beat, rsp stalled on beat 2
    send_cmd(1'b0, 32'h0000_1003, 8'd2);
    read_beat(32'h0000_1000, 32'h1111_1111, 1, 0);
    read_beat(32'h0000_1004, 32'h2222_2222, 1, 10);
    read_beat(32'h0000_1008, 32'h3333_3333, 1, 0);
    chk("rd done", done, 1);
    chk("rd err", err, 0);
    next_cyc();
    chk("rd done pulse", done, 0);
    chk("rd back idle", cmd_ready, 1);

    // write burst of 2, rsp_ready held low
    send_cmd(1'b1, 32'h0000_2000, 8'd1);
    write_beat(32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 0);
    write_beat(32'h0000_2004, 32'h1234_5678, 4'h3, 1);
    chk("wr done", done, 1);
    chk("wr err", err, 0);
    chk("wr done rsp_valid", rsp_valid, 0);
    next_cyc();
    chk("wr done pulse", done, 0);

    // timeout: mem_ready never arrives, second wr entry stays offered
    send_cmd(1'b1, 32'h0000_3000, 8'd1);
    chk("to wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = 32'hAAAA_AAAA;
    wr_strb  = 4'hF;
    next_cyc();
    wr_data  = 32'h5555_5555;
    chk("to mem_valid 1", mem_valid, 1);
    for (int i = 2; i <= 5; i++) begin
      next_cyc();
      chk("to mem_valid held", mem_valid, 1);
      chk("to wr_ready held", wr_ready, 0);
    end
    next_cyc();
    chk("to mem_valid dropped", mem_valid, 0);
    chk("to done", done, 1);
    chk("to err", err, 1);
    chk("to wr_ready done", wr_ready, 0);
    next_cyc();
    chk("to done pulse", done, 0);
    chk("to err cleared", err, 0);
    chk("to wr_ready idle", wr_ready, 0);
    wr_valid = 1'b0;

    // ready on the timeout cycle counts as success
    send_cmd(1'b0, 32'h0000_4000, 8'd0);
    read_beat(32'h0000_4000, 32'hCAFE_F00D, 4, 0);
    chk("edge done", done, 1);
    chk("edge err", err, 0);
    next_cyc();

    // address wrap
    send_cmd(1'b0, 32'hFFFF_FFFC, 8'd1);
    read_beat(32'hFFFF_FFFC, 32'h0101_0101, 0, 0);
    read_beat(32'h0000_0000, 32'h0202_0202, 0, 0);
    chk("wrap done", done, 1);
    chk("wrap err", err, 0);
    next_cyc();

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    next_cyc();
    mem_ready = 1'b0;
    chk("idle rsp_valid", rsp_valid, 0);
    chk("idle rsp_data", rsp_data, 32'h0202_0202);
    chk("idle done", done, 0);
    chk("idle mem_valid", mem_valid, 0);

    // reset mid-beat
    send_cmd(1'b1, 32'h0000_5000, 8'd0);
    wr_valid = 1'b1;
    wr_data  = 32'h9999_9999;
    wr_strb  = 4'h6;
    next_cyc();
    wr_valid = 1'b0;
    chk("mid mem_valid", mem_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid rst cmd_ready", cmd_ready, 0);
    next_cyc();
    chk("mid rst mem_valid", mem_valid, 0);
    chk("mid rst state", state_dbg, 0);
    chk("mid rst done", done, 0);
    chk("mid rst mem_addr", mem_addr, 0);
    chk("mid rst mem_wdata", mem_wdata, 0);
    chk("mid rst mem_wstrb", mem_wstrb, 0);
    chk("mid rst rsp_data", rsp_data, 0);
    rst = 1'b0;
    #1;
    chk("mid post cmd_ready", cmd_ready, 1);
    next_cyc();
    chk("mid no done 1", done, 0);
    next_cyc();
    chk("mid no done 2", done, 0);
    chk("mid idle mem_valid", mem_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
